// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
// Holds the 4-bit opcode encodings and the first opcode of the illegal range.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'h0;
   localparam logic [3:0] ALU_OR   = 4'h1;
   localparam logic [3:0] ALU_XOR  = 4'h2;
   localparam logic [3:0] ALU_ADD  = 4'h3;
   localparam logic [3:0] ALU_SUB  = 4'h4;
   localparam logic [3:0] ALU_SLT  = 4'h5;
   localparam logic [3:0] ALU_SLTU = 4'h6;
   localparam logic [3:0] ALU_SLL  = 4'h7;
   localparam logic [3:0] ALU_SRL  = 4'h8;
   localparam logic [3:0] ALU_SRA  = 4'h9;

   // Opcodes at or above this value are undefined.
   localparam logic [3:0] ALU_ILL_MIN = 4'hA;

endpackage

// File: rtl/alu_addsub.sv
// Adder/subtractor used by stage 1 of alu_pipe.
// Ports:
//   a, b      operands
//   sub       1 = compute a + ~b + 1, 0 = compute a + b
//   sum       WIDTH-bit result
//   carry     carry-out of the top bit (for sub: 1 = no borrow)
//   overflow  signed overflow of the operation actually performed
// ADDER_TYPE 0 builds a ripple-carry chain, 1 builds 4-bit lookahead groups
// rippling between groups. Both give identical results.
module alu_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDER_TYPE = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;

   assign b_eff = sub ? ~b : b;
   assign g     = a & b_eff;
   assign p     = a ^ b_eff;

   generate
      if (ADDER_TYPE == 0) begin : g_rca
         always_comb begin
            logic [WIDTH:0] cc;
            cc    = '0;
            cc[0] = sub;
            for (int i = 0; i < WIDTH; i++) begin
               cc[i+1] = g[i] | (p[i] & cc[i]);
            end
            sum   = p ^ cc[WIDTH-1:0];
            carry = cc[WIDTH];
         end
      end else begin : g_cla
         always_comb begin
            logic [WIDTH:0] cc;
            logic [3:0]     gv;
            logic [3:0]     pv;
            logic           ci;
            cc    = '0;
            gv    = '0;
            pv    = '0;
            ci    = 1'b0;
            cc[0] = sub;
            for (int k = 0; k < WIDTH / 4; k++) begin
               gv = g[4*k +: 4];
               pv = p[4*k +: 4];
               ci = cc[4*k];
               cc[4*k+1] = gv[0] | (pv[0] & ci);
               cc[4*k+2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & ci);
               cc[4*k+3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0])
                         | (pv[2] & pv[1] & pv[0] & ci);
               cc[4*k+4] = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1])
                         | (pv[3] & pv[2] & pv[1] & gv[0]) | ((&pv) & ci);
            end
            sum   = p ^ cc[WIDTH-1:0];
            carry = cc[WIDTH];
         end
      end
   endgenerate

   // With b_eff = ~b for subtraction this matches both the add rule
   // (signs equal) and the subtract rule (signs of a and b differ).
   assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear of both pipeline stages
//   in_valid/in_ready, in_a, in_b, in_sel, in_tag   request side
//   out_valid/out_ready, out_y, out_zero, out_carry, out_overflow,
//   out_illegal, out_tag                            result side
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; valid never depends on ready, and in_ready never looks at in_valid.
// Stage 1 registers the request; its result logic feeds stage 2, which
// registers result and flags straight onto the outputs.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDER_TYPE = 0,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SH_W = $clog2(WIDTH);

   logic             s1_v;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [3:0]       s1_sel;
   logic [TAG_W-1:0] s1_tag;
   logic             s2_v;

   logic             s1_adv;
   logic             s2_adv;
   logic             accept;

   logic             use_sub;
   logic [WIDTH-1:0] sum;
   logic             add_c;
   logic             add_o;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] r_y;
   logic             r_c;
   logic             r_o;
   logic             r_il;

   assign s2_adv    = !s2_v || out_ready;
   assign s1_adv    = !s1_v || s2_adv;
   assign in_ready  = s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_v;

   // Compares reuse the subtractor: SLT from sign^overflow, SLTU from borrow.
   assign use_sub = (s1_sel == ALU_SUB) || (s1_sel == ALU_SLT) || (s1_sel == ALU_SLTU);
   assign shamt   = s1_b[SH_W-1:0];

   alu_addsub #(
      .WIDTH      (WIDTH),
      .ADDER_TYPE (ADDER_TYPE)
   ) u_addsub (
      .a        (s1_a),
      .b        (s1_b),
      .sub      (use_sub),
      .sum      (sum),
      .carry    (add_c),
      .overflow (add_o)
   );

   always_comb begin
      r_y  = '0;
      r_c  = 1'b0;
      r_o  = 1'b0;
      r_il = (s1_sel >= ALU_ILL_MIN);
      case (s1_sel)
         ALU_AND:  r_y = s1_a & s1_b;
         ALU_OR:   r_y = s1_a | s1_b;
         ALU_XOR:  r_y = s1_a ^ s1_b;
         ALU_ADD, ALU_SUB: begin
            r_y = sum;
            r_c = add_c;
            r_o = add_o;
         end
         ALU_SLT:  r_y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_o};
         ALU_SLTU: r_y = {{(WIDTH-1){1'b0}}, ~add_c};
         ALU_SLL:  r_y = s1_a << shamt;
         ALU_SRL:  r_y = s1_a >> shamt;
         ALU_SRA:  r_y = $unsigned($signed(s1_a) >>> shamt);
         default:  r_y = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_sel <= '0;
         s1_tag <= '0;
      end else begin
         if (flush) begin
            s1_v <= 1'b0;
         end else if (s1_adv) begin
            s1_v <= in_valid;
         end
         if (accept) begin
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_sel <= in_sel;
            s1_tag <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v         <= 1'b0;
         out_y        <= '0;
         out_zero     <= 1'b0;
         out_carry    <= 1'b0;
         out_overflow <= 1'b0;
         out_illegal  <= 1'b0;
         out_tag      <= '0;
      end else begin
         if (flush) begin
            s2_v <= 1'b0;
         end else if (s2_adv) begin
            s2_v <= s1_v;
         end
         if (s2_adv && s1_v) begin
            out_y        <= r_y;
            out_zero     <= (r_y == '0);
            out_carry    <= r_c;
            out_overflow <= r_o;
            out_illegal  <= r_il;
            out_tag      <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three instances share one stimulus stream
// (32-bit ripple, 32-bit lookahead, 16-bit ripple). Accepted requests push
// expected results into per-instance queues; monitors pop and compare on
// every output transfer.
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_sel;
   logic [3:0]  in_tag;
   logic        out_ready;

   logic        r_in_ready, r_valid, r_zero, r_carry, r_ovf, r_ill;
   logic [31:0] r_y;
   logic [3:0]  r_tag;
   logic        c_in_ready, c_valid, c_zero, c_carry, c_ovf, c_ill;
   logic [31:0] c_y;
   logic [3:0]  c_tag;
   logic        h_in_ready, h_valid, h_zero, h_carry, h_ovf, h_ill;
   logic [15:0] h_y;
   logic [3:0]  h_tag;

   logic [39:0] exp_q_r[$];
   logic [39:0] exp_q_c[$];
   logic [23:0] exp_q_h[$];
   logic [39:0] cur_exp;
   logic [39:0] held;
   logic        held_v = 1'b0;
   logic        rnd_mode = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(32), .ADDER_TYPE(0), .TAG_W(4)) dut_rca (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r_in_ready),
      .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag), .out_valid(r_valid),
      .out_ready(out_ready), .out_y(r_y), .out_zero(r_zero), .out_carry(r_carry),
      .out_overflow(r_ovf), .out_illegal(r_ill), .out_tag(r_tag));

   alu_pipe #(.WIDTH(32), .ADDER_TYPE(1), .TAG_W(4)) dut_cla (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag), .out_valid(c_valid),
      .out_ready(out_ready), .out_y(c_y), .out_zero(c_zero), .out_carry(c_carry),
      .out_overflow(c_ovf), .out_illegal(c_ill), .out_tag(c_tag));

   alu_pipe #(.WIDTH(16), .ADDER_TYPE(0), .TAG_W(4)) dut_w16 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(h_in_ready),
      .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_sel(in_sel), .in_tag(in_tag), .out_valid(h_valid),
      .out_ready(out_ready), .out_y(h_y), .out_zero(h_zero), .out_carry(h_carry),
      .out_overflow(h_ovf), .out_illegal(h_ill), .out_tag(h_tag));

   // Reference model: returns {illegal, overflow, carry, zero, y[31:0]}.
   function automatic logic [35:0] model(input int w, input logic [31:0] a_in,
                                         input logic [31:0] b_in, input logic [3:0] sel);
      logic [63:0] mask, a, b, s, y;
      logic        c, o, il;
      longint      sa, sb;
      int          sh, m;
      mask = (64'd1 << w) - 64'd1;
      a = {32'd0, a_in} & mask;
      b = {32'd0, b_in} & mask;
      m = w - 1;
      sh = int'(b_in) & (w - 1);
      y = '0; s = '0; c = 1'b0; o = 1'b0; il = 1'b0;
      sa = a[m] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb = b[m] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      case (sel)
         4'h0: y = a & b;
         4'h1: y = a | b;
         4'h2: y = a ^ b;
         4'h3: begin s = a + b; y = s & mask; c = s[w]; o = (a[m] == b[m]) && (y[m] != a[m]); end
         4'h4: begin
            s = a + ((~b) & mask) + 64'd1; y = s & mask; c = s[w];
            o = (a[m] != b[m]) && (y[m] != a[m]);
         end
         4'h5: y = (sa < sb) ? 64'd1 : 64'd0;
         4'h6: y = (a < b) ? 64'd1 : 64'd0;
         4'h7: y = (a << sh) & mask;
         4'h8: y = a >> sh;
         4'h9: y = (a >> sh) | (a[m] ? (mask & ~(mask >> sh)) : 64'd0);
         default: il = 1'b1;
      endcase
      return {il, o, c, (y == 64'd0), y[31:0]};
   endfunction

   function automatic logic [39:0] pk32(input logic [31:0] y, input logic z, input logic c,
                                        input logic o, input logic il, input logic [3:0] tag);
      return {tag, il, o, c, z, y};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard: push on accepted request ----------------
   always @(posedge clk) begin
      logic [35:0] m16;
      if (rst_n && flush) begin
         exp_q_r.delete();
         exp_q_c.delete();
         exp_q_h.delete();
      end else if (rst_n && in_valid && r_in_ready) begin
         m16 = model(16, in_a, in_b, in_sel);
         exp_q_r.push_back(cur_exp);
         exp_q_c.push_back(cur_exp);
         exp_q_h.push_back({in_tag, m16[35:32], m16[15:0]});
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && r_valid && out_ready) begin
         if (exp_q_r.size() == 0) chk("rca_unexpected", {60'd0, r_tag}, 64'hDEAD);
         else chk("rca_result", {24'd0, r_tag, r_ill, r_ovf, r_carry, r_zero, r_y}, {24'd0, exp_q_r.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (rst_n && c_valid && out_ready) begin
         if (exp_q_c.size() == 0) chk("cla_unexpected", {60'd0, c_tag}, 64'hDEAD);
         else chk("cla_result", {24'd0, c_tag, c_ill, c_ovf, c_carry, c_zero, c_y}, {24'd0, exp_q_c.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (rst_n && h_valid && out_ready) begin
         if (exp_q_h.size() == 0) chk("w16_unexpected", {60'd0, h_tag}, 64'hDEAD);
         else chk("w16_result", {40'd0, h_tag, h_ill, h_ovf, h_carry, h_zero, h_y}, {40'd0, exp_q_h.pop_front()});
      end
   end

   // Outputs must not move while a result is stalled.
   always @(negedge clk) begin
      if (r_valid && !out_ready) begin
         if (held_v) chk("stall_hold", {24'd0, r_tag, r_ill, r_ovf, r_carry, r_zero, r_y}, {24'd0, held});
         held   = {r_tag, r_ill, r_ovf, r_carry, r_zero, r_y};
         held_v = 1'b1;
      end else begin
         held_v = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (rnd_mode) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                          input logic [3:0] tag, input logic [39:0] exp);
      in_a = a; in_b = b; in_sel = sel; in_tag = tag; cur_exp = exp; in_valid = 1'b1;
   endtask

   // Offers a request and returns just after the edge that accepts it.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                       input logic [3:0] tag, input logic [39:0] exp, output int waits);
      logic got;
      set_req(a, b, sel, tag, exp);
      waits = 0;
      forever begin
         @(negedge clk);
         got = r_in_ready;
         @(posedge clk);
         #1;
         if (got) break;
         waits++;
         if (waits > 200) begin
            chk("send_timeout", 64'd0, 64'd1);
            break;
         end
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string nm);
      chk({nm, "_rca"}, {22'd0, r_valid, r_in_ready, r_tag, r_ill, r_ovf, r_carry, r_zero, r_y},
          {22'd0, 1'b0, 1'b1, 40'd0});
      chk({nm, "_cla"}, {22'd0, c_valid, c_in_ready, c_tag, c_ill, c_ovf, c_carry, c_zero, c_y},
          {22'd0, 1'b0, 1'b1, 40'd0});
      chk({nm, "_w16"}, {38'd0, h_valid, h_in_ready, h_tag, h_ill, h_ovf, h_carry, h_zero, h_y},
          {38'd0, 1'b0, 1'b1, 24'd0});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          w;
      logic [31:0] ra, rb;
      logic [3:0]  rs;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_sel = '0; in_tag = '0; out_ready = 1'b1; cur_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_n = 1'b1;
      wait_cycles(1);

      // 1: single ADD, latency of two edges
      send(32'd5, 32'd3, ALU_ADD, 4'd1, pk32(32'd8, 0, 0, 0, 0, 4'd1), w);
      idle();
      @(negedge clk); chk("lat_edge1", {63'd0, r_valid}, 64'd0);
      @(negedge clk); chk("lat_edge2", {63'd0, r_valid}, 64'd1);
      wait_cycles(3);

      // 2: back-to-back corner arithmetic
      send(32'hFFFFFFFF, 32'd1, ALU_ADD, 4'd2, pk32(32'h0, 1, 1, 0, 0, 4'd2), w);
      send(32'h80000000, 32'd1, ALU_SUB, 4'd3, pk32(32'h7FFFFFFF, 0, 1, 1, 0, 4'd3), w);
      chk("thru_1", w, 0);
      send(32'd3, 32'd5, ALU_SUB, 4'd4, pk32(32'hFFFFFFFE, 0, 0, 0, 0, 4'd4), w);
      chk("thru_2", w, 0);
      send(32'h80000000, 32'd4, ALU_SRA, 4'd5, pk32(32'hF8000000, 0, 0, 0, 0, 4'd5), w);
      chk("thru_3", w, 0);
      idle();
      wait_cycles(4);

      // 5: illegal opcode and compares
      send(32'd1, 32'd1, 4'hB, 4'd6, pk32(32'h0, 1, 0, 0, 1, 4'd6), w);
      send(32'hFFFFFFFF, 32'd1, ALU_SLT, 4'd7, pk32(32'h1, 0, 0, 0, 0, 4'd7), w);
      send(32'hFFFFFFFF, 32'd1, ALU_SLTU, 4'd8, pk32(32'h0, 1, 0, 0, 0, 4'd8), w);
      send(32'hF0F0F0F0, 32'h3C3C3C3C, ALU_AND, 4'd9, pk32(32'h30303030, 0, 0, 0, 0, 4'd9), w);
      send(32'h80000000, 32'd31, ALU_SRL, 4'd10, pk32(32'h1, 0, 0, 0, 0, 4'd10), w);
      idle();
      wait_cycles(4);

      // 3: backpressure with three requests
      out_ready = 1'b0;
      send(32'hA5A5A5A5, 32'hFFFF0000, ALU_XOR, 4'd5, pk32(32'h5A5AA5A5, 0, 0, 0, 0, 4'd5), w);
      send(32'h0F0F0000, 32'h000000F0, ALU_OR, 4'd6, pk32(32'h0F0F00F0, 0, 0, 0, 0, 4'd6), w);
      set_req(32'd1, 32'h1F, ALU_SLL, 4'd7, pk32(32'h80000000, 0, 0, 0, 0, 4'd7));
      repeat (3) begin
         @(negedge clk); chk("stall_in_ready", {63'd0, r_in_ready}, 64'd0);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(negedge clk); chk("ready_back", {63'd0, r_in_ready}, 64'd1);
      @(posedge clk); #1; idle();
      wait_cycles(4);

      // 4a: flush with both stages full plus a request offered
      out_ready = 1'b0;
      send(32'd10, 32'd20, ALU_ADD, 4'd8, pk32(32'd30, 0, 0, 0, 0, 4'd8), w);
      send(32'd11, 32'd21, ALU_ADD, 4'd9, pk32(32'd32, 0, 0, 0, 0, 4'd9), w);
      set_req(32'd12, 32'd22, ALU_ADD, 4'd10, pk32(32'd34, 0, 0, 0, 0, 4'd10));
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0; idle();
      @(negedge clk);
      chk("flush_valid", {63'd0, r_valid}, 64'd0);
      chk("flush_ready", {63'd0, r_in_ready}, 64'd1);
      out_ready = 1'b1;
      wait_cycles(5);
      // 4b: flush while in_ready reads 1
      send(32'd13, 32'd23, ALU_ADD, 4'd12, pk32(32'd36, 0, 0, 0, 0, 4'd12), w);
      set_req(32'd14, 32'd24, ALU_ADD, 4'd13, pk32(32'd38, 0, 0, 0, 0, 4'd13));
      flush = 1'b1;
      @(negedge clk); chk("flush_rdy_high", {63'd0, r_in_ready}, 64'd1);
      @(posedge clk); #1; flush = 1'b0; idle();
      @(negedge clk); chk("flush2_valid", {63'd0, r_valid}, 64'd0);
      wait_cycles(5);
      send(32'd7, 32'd7, ALU_XOR, 4'd11, pk32(32'd0, 1, 0, 0, 0, 4'd11), w);
      idle();
      wait_cycles(4);

      // 6: asynchronous reset with both stages full
      out_ready = 1'b0;
      send(32'd1, 32'd2, ALU_ADD, 4'd1, pk32(32'd3, 0, 0, 0, 0, 4'd1), w);
      send(32'd2, 32'd2, ALU_ADD, 4'd2, pk32(32'd4, 0, 0, 0, 0, 4'd2), w);
      idle();
      @(negedge clk); #2;
      rst_n = 1'b0;
      exp_q_r.delete(); exp_q_c.delete(); exp_q_h.delete();
      #1;
      check_reset_state("async_reset");
      @(posedge clk); #1; rst_n = 1'b1;
      out_ready = 1'b1;
      wait_cycles(4);

      // random ops with random backpressure
      rnd_mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         ra = $urandom();
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
         rs = 4'($urandom_range(0, 11));
         if (i % 17 == 0) begin ra = 32'h80000000; rb = 32'h7FFFFFFF; end
         send(ra, rb, rs, 4'(i), {4'(i), model(32, ra, rb, rs)}, w);
      end
      idle();
      rnd_mode = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;

      for (int k = 0; k < 300 && (exp_q_r.size() + exp_q_c.size() + exp_q_h.size()) != 0; k++)
         @(posedge clk);
      wait_cycles(2);
      chk("drain_rca", exp_q_r.size(), 0);
      chk("drain_cla", exp_q_c.size(), 0);
      chk("drain_w16", exp_q_h.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
